// File: rtl/dds_pkg.sv
// Shared definitions for the DDS-side signal chain: default widths, the
// demodulator state encoding and a width-agnostic saturating adder.
package dds_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ACC_W  = 48;
   localparam int DEF_CNT_W  = 20;

   // Working width of sat_add; any accumulator narrower than this can use it.
   localparam int SAT_W = 64;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } demod_state_t;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    clip;
   } sat_res_t;

   // Adds two sign-extended operands and clamps the result to the signed
   // range of an acc_w-bit accumulator, flagging whether clamping happened.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                        input logic signed [SAT_W-1:0] addend,
                                        input int                      acc_w);
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] one;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      sat_res_t              r;
      one    = '0;
      one[0] = 1'b1;
      s      = (SAT_W+1)'(acc) + (SAT_W+1)'(addend);
      hi     = (one <<< (acc_w - 1)) - one;
      lo     = -hi - one;
      r.sum  = s[SAT_W-1:0];
      r.clip = 1'b0;
      if (s > hi) begin
         r.sum  = hi[SAT_W-1:0];
         r.clip = 1'b1;
      end else if (s < lo) begin
         r.sum  = lo[SAT_W-1:0];
         r.clip = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/iq_lockin_demod_mac_sat.sv
// One demodulator arm: registered signed product followed by a saturating
// accumulator that dumps its total and sticky clip flag on the last sample.
module mac_sat
   import dds_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     accept,
   input  logic                     last_in,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     dump_valid,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     sat
);

   logic signed [2*DATA_W-1:0] prod_q;
   logic                       v1_q;
   logic                       last1_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_next;
   logic                       sticky_q;
   logic                       clip;
   sat_res_t                   res;

   always_comb begin
      res      = sat_add(SAT_W'(acc_q), SAT_W'(prod_q), ACC_W);
      acc_next = res.sum[ACC_W-1:0];
      clip     = res.clip;
   end

   // clear wins over a pending last product so an aborted window never dumps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_q     <= '0;
         v1_q       <= 1'b0;
         last1_q    <= 1'b0;
         acc_q      <= '0;
         sticky_q   <= 1'b0;
         dump_valid <= 1'b0;
         sum        <= '0;
         sat        <= 1'b0;
      end else if (clear) begin
         v1_q       <= 1'b0;
         last1_q    <= 1'b0;
         acc_q      <= '0;
         sticky_q   <= 1'b0;
         dump_valid <= 1'b0;
      end else begin
         v1_q       <= accept;
         dump_valid <= v1_q && last1_q;
         if (accept) begin
            prod_q  <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            last1_q <= last_in;
         end
         if (v1_q) begin
            if (last1_q) begin
               sum      <= acc_next;
               sat      <= sticky_q | clip;
               acc_q    <= '0;
               sticky_q <= 1'b0;
            end else begin
               acc_q    <= acc_next;
               sticky_q <= sticky_q | clip;
            end
         end
      end
   end

endmodule

// File: rtl/iq_lockin_demod.sv
// Lock-in IQ demodulator: mixes the ADC stream with a DDS cos/sin pair and
// emits one integrated I/Q pair per programmable window.
module iq_lockin_demod
   import dds_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     en,
   input  logic [CNT_W-1:0]         dump_len,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] adc_data,
   input  logic signed [DATA_W-1:0] cos_ref,
   input  logic signed [DATA_W-1:0] sin_ref,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  i_sum,
   output logic signed [ACC_W-1:0]  q_sum,
   output logic                     sat,
   output logic                     busy
);

   demod_state_t     state_q;
   demod_state_t     state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] dump_len_eff;
   logic             abort;
   logic             accept;
   logic             last;
   logic             i_dump;
   logic             q_dump;
   logic             i_sat;
   logic             q_sat;

   always_comb dump_len_eff = (dump_len == '0) ? CNT_W'(1) : dump_len;

   assign last = (cnt_q == len_q - CNT_W'(1));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Dropping en in RUN aborts the window; samples are only taken while en holds.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      abort   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
               abort   = 1'b1;
            end else begin
               accept = in_valid;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Window length is resampled at every boundary so windows run back to back.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (abort) begin
         cnt_q <= '0;
      end else if (state_q == ST_IDLE && en) begin
         cnt_q <= '0;
         len_q <= dump_len_eff;
      end else if (accept) begin
         if (last) begin
            cnt_q <= '0;
            len_q <= dump_len_eff;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   mac_sat #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac_i (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .clear      (abort),
      .accept     (accept),
      .last_in    (last),
      .a          (adc_data),
      .b          (cos_ref),
      .dump_valid (i_dump),
      .sum        (i_sum),
      .sat        (i_sat)
   );

   mac_sat #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac_q (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .clear      (abort),
      .accept     (accept),
      .last_in    (last),
      .a          (adc_data),
      .b          (sin_ref),
      .dump_valid (q_dump),
      .sum        (q_sum),
      .sat        (q_sat)
   );

   assign out_valid = i_dump & q_dump;
   assign sat       = i_sat | q_sat;

endmodule

// File: tb/tb_iq_lockin_demod.sv
// Directed bench for iq_lockin_demod with a narrow 34-bit accumulator so the
// saturation window is reachable in a handful of samples.
module tb_iq_lockin_demod;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 34;
   localparam int CNT_W  = 20;

   logic                     sys_clk = 1'b0;
   logic                     sys_rst_n;
   logic                     en;
   logic [CNT_W-1:0]         dump_len;
   logic                     in_valid;
   logic signed [DATA_W-1:0] adc_data;
   logic signed [DATA_W-1:0] cos_ref;
   logic signed [DATA_W-1:0] sin_ref;
   logic                     out_valid;
   logic signed [ACC_W-1:0]  i_sum;
   logic signed [ACC_W-1:0]  q_sum;
   logic                     sat;
   logic                     busy;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int base;

   logic signed [ACC_W-1:0] cap_i [0:63];
   logic signed [ACC_W-1:0] cap_q [0:63];
   logic                    cap_s [0:63];

   always #5 sys_clk = ~sys_clk;

   iq_lockin_demod #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .CNT_W  (CNT_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (en),
      .dump_len  (dump_len),
      .in_valid  (in_valid),
      .adc_data  (adc_data),
      .cos_ref   (cos_ref),
      .sin_ref   (sin_ref),
      .out_valid (out_valid),
      .i_sum     (i_sum),
      .q_sum     (q_sum),
      .sat       (sat),
      .busy      (busy)
   );

   // Each result pulse spans one full cycle, so one falling edge captures it.
   always @(negedge sys_clk) begin
      if (out_valid) begin
         if (pulses < 64) begin
            cap_i[pulses] = i_sum;
            cap_q[pulses] = q_sum;
            cap_s[pulses] = sat;
         end
         pulses = pulses + 1;
      end
   end

   task automatic apply_stimulus(input logic en_v, input logic vld,
                                 input int adc, input int cs, input int sn);
      en       = en_v;
      in_valid = vld;
      adc_data = 16'(adc);
      cos_ref  = 16'(cs);
      sin_ref  = 16'(sn);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      dump_len  = '0;
      apply_stimulus(0, 0, 0, 0, 0);
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_valid", out_valid, 0);
      check_output("rst_i", i_sum, 0);
      check_output("rst_q", q_sum, 0);
      check_output("rst_sat", sat, 0);
      sys_rst_n = 1'b1;

      $display("[TB] constant input, window 4");
      dump_len = 4;
      base     = pulses;
      apply_stimulus(1, 0, 0, 0, 0);
      check_output("t1_busy", busy, 1);
      for (int n = 1; n <= 12; n++) begin
         apply_stimulus(1, 1, 16384, 16384, 0);
         check_output("t1_valid", out_valid, (n == 5 || n == 9));
         if (n == 5 || n == 9) begin
            check_output("t1_i", i_sum, 64'sd1073741824);
            check_output("t1_q", q_sum, 0);
            check_output("t1_sat", sat, 0);
         end
      end
      apply_stimulus(1, 0, 0, 0, 0);
      check_output("t1_valid_last", out_valid, 1);
      check_output("t1_i_last", i_sum, 64'sd1073741824);
      apply_stimulus(1, 0, 0, 0, 0);
      check_output("t1_valid_drop", out_valid, 0);
      check_output("t1_pulses", pulses - base, 3);
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("t1_idle_busy", busy, 0);

      $display("[TB] gapped valid, window 3");
      dump_len = 3;
      base     = pulses;
      apply_stimulus(1, 1, 16384, 16384, 0);
      for (int n = 1; n <= 10; n++) apply_stimulus(1, n[0], 16384, 16384, 0);
      for (int n = 0; n < 3; n++) apply_stimulus(1, 0, 0, 0, 0);
      check_output("t2_pulses", pulses - base, 1);
      check_output("t2_i", cap_i[base], 64'sd805306368);
      check_output("t2_q", cap_q[base], 0);
      check_output("t2_sat", cap_s[base], 0);
      apply_stimulus(0, 0, 0, 0, 0);

      $display("[TB] quadrature, then saturation and recovery");
      dump_len = 10;
      base     = pulses;
      apply_stimulus(1, 0, 0, 0, 0);
      dump_len = 16;
      for (int n = 0; n < 10; n++) apply_stimulus(1, 1, -1000, 0, 2000);
      for (int n = 0; n < 16; n++) apply_stimulus(1, 1, -32768, -32768, 0);
      for (int n = 0; n < 16; n++) apply_stimulus(1, 1, 0, -32768, 0);
      for (int n = 0; n < 3; n++) apply_stimulus(1, 0, 0, 0, 0);
      check_output("t3_pulses", pulses - base, 3);
      check_output("t3_quad_i", cap_i[base], 0);
      check_output("t3_quad_q", cap_q[base], -64'sd20000000);
      check_output("t3_quad_sat", cap_s[base], 0);
      check_output("t3_sat_i", cap_i[base+1], 64'sd8589934591);
      check_output("t3_sat_q", cap_q[base+1], 0);
      check_output("t3_sat_flag", cap_s[base+1], 1);
      check_output("t3_zero_i", cap_i[base+2], 0);
      check_output("t3_zero_sat", cap_s[base+2], 0);
      apply_stimulus(0, 0, 0, 0, 0);

      $display("[TB] abort mid-window, then a fresh window of 8");
      dump_len = 8;
      base     = pulses;
      apply_stimulus(1, 0, 0, 0, 0);
      for (int n = 0; n < 5; n++) apply_stimulus(1, 1, 100, 7, 3);
      apply_stimulus(0, 1, 100, 7, 3);
      check_output("t4_abort_busy", busy, 0);
      apply_stimulus(1, 0, 0, 0, 0);
      for (int n = 0; n < 8; n++) apply_stimulus(1, 1, 10, 20, -30);
      for (int n = 0; n < 3; n++) apply_stimulus(1, 0, 0, 0, 0);
      check_output("t4_pulses", pulses - base, 1);
      check_output("t4_i", cap_i[base], 64'sd1600);
      check_output("t4_q", cap_q[base], -64'sd2400);
      apply_stimulus(0, 0, 0, 0, 0);

      $display("[TB] abort with last product in flight");
      dump_len = 2;
      base     = pulses;
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(1, 1, 5, 5, 5);
      apply_stimulus(1, 1, 5, 5, 5);
      for (int n = 0; n < 4; n++) apply_stimulus(0, 0, 0, 0, 0);
      check_output("t5_pulses", pulses - base, 0);

      $display("[TB] reset mid-window, then single-sample windows");
      dump_len = 4;
      apply_stimulus(1, 0, 0, 0, 0);
      for (int n = 0; n < 3; n++) apply_stimulus(1, 1, 16384, 16384, 0);
      sys_rst_n = 1'b0;
      apply_stimulus(1, 1, 16384, 16384, 0);
      check_output("t6_rst_valid", out_valid, 0);
      check_output("t6_rst_i", i_sum, 0);
      check_output("t6_rst_q", q_sum, 0);
      check_output("t6_rst_busy", busy, 0);
      check_output("t6_rst_sat", sat, 0);
      sys_rst_n = 1'b1;
      dump_len  = 0;
      base      = pulses;
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(1, 1, 3, 5, -7);
      apply_stimulus(1, 1, -2, 9, 4);
      apply_stimulus(1, 1, 11, 11, 0);
      for (int n = 0; n < 3; n++) apply_stimulus(1, 0, 0, 0, 0);
      check_output("t6_pulses", pulses - base, 3);
      check_output("t6_i0", cap_i[base], 64'sd15);
      check_output("t6_q0", cap_q[base], -64'sd21);
      check_output("t6_i1", cap_i[base+1], -64'sd18);
      check_output("t6_q1", cap_q[base+1], -64'sd8);
      check_output("t6_i2", cap_i[base+2], 64'sd121);
      check_output("t6_q2", cap_q[base+2], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iq_lockin_demod.md
# iq_lockin_demod

Lock-in IQ demodulator sitting downstream of the 16-channel DDS. It mixes one ADC sample stream with a selected DDS cos/sin reference pair and integrates the I and Q products over a programmable window. It emits one I/Q sum per window for the servo loop that later retunes `pinc`. This block consumes the DDS outputs; the DDS produces them.

## Interface
- `DATA_W`, 16, width of ADC sample and reference words (signed two's complement).
- `ACC_W`, 48, width of the I/Q accumulators and outputs.
- `CNT_W`, 20, width of the window-length input and sample counter.

- `sys_clk`  in  1  single clock; all logic on rising edge.
- `sys_rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  run enable; low aborts and holds the block idle.
- `dump_len`  in  CNT_W  samples per window; 0 treated as 1.
- `in_valid`  in  1  `adc_data`/`cos_ref`/`sin_ref` valid this cycle.
- `adc_data`  in  DATA_W  signed ADC sample.
- `cos_ref`  in  DATA_W  signed DDS cosine, same cycle as sample.
- `sin_ref`  in  DATA_W  signed DDS sine, same cycle as sample.
- `out_valid`  out  1  one-cycle pulse; `i_sum`/`q_sum`/`sat` valid.
- `i_sum`  out  ACC_W  signed Σ adc·cos over the window.
- `q_sum`  out  ACC_W  signed Σ adc·sin over the window.
- `sat`  out  1  some accumulator clipped during this window.
- `busy`  out  1  high in RUN state.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN when `en`=1; `dump_len` latched into `len_q` on that transition.
  - RUN→IDLE when `en`=0: abort. Counter, accumulators, pipeline valid bits and sticky sat are cleared. No `out_valid` for the partial window.
- In IDLE, `in_valid` is ignored.
- Stage 1 (mult): on accepted sample (RUN and `in_valid`), register p_i = adc·cos and p_q = adc·sin as 2·DATA_W signed, plus a `last` flag. Also register `v1`.
  - -32768·-32768 = 2^30 fits; products never wrap.
- Counter `cnt` increments per accepted sample. `last` = (cnt == len_q−1). On last, `cnt`←0 and `len_q`←current `dump_len`, so the next window begins with no gap.
- Stage 2 (acc): when `v1`, sum = acc + sign-extended p.
  - Saturate to ±(2^(ACC_W−1)) bounds: max 2^(ACC_W−1)−1, min −2^(ACC_W−1). Set sticky sat on clip.
  - If `last`: drive `i_sum`/`q_sum` ← saturated sum, `sat` ← sticky | clip-this-cycle, pulse `out_valid`. Reload acc ← 0 and sticky ← 0.
  - Else acc ← saturated sum.
- `in_valid` may be gapped arbitrarily; only accepted samples count.
- No backpressure: outputs are held until the next pulse and must be captured on `out_valid`.

## Timing
- Reset (`sys_rst_n`=0 at edge): state IDLE, `out_valid`=0, `i_sum`=0, `q_sum`=0, `sat`=0, `busy`=0. Counter, accumulators, `len_q` and pipeline valids are 0.
- Reset mid-window discards everything; no `out_valid` follows.
- Latency: last sample accepted at edge t → `out_valid` high for edge t+2 only.
- Back-to-back windows: a sample accepted at t+1 after the last at t belongs to the new window.
- `en` falling while a last product sits in stage 1: aborted; no pulse.
- `dump_len` changes mid-window take effect at the next window boundary.
- Counter wrap cannot occur: `cnt` ≤ len_q−1 < 2^CNT_W.
- Throughput: one sample per clock.

## Structure
- Shared package `dds_pkg`: DATA_W/ACC_W/CNT_W defaults, state enum, and saturating-add function (`sat_add`, returns sum plus clip flag).
- One sub-module `mac_sat` (signed multiply register + saturating accumulator with dump), instantiated twice for I and Q. The top holds the FSM and counter.

## Test plan
- Constant input: `en`=1, `dump_len`=4, adc=16384, cos=16384, sin=0, `in_valid` every cycle → `i_sum`=1073741824, `q_sum`=0, `sat`=0, `out_valid` 2 cycles after the 4th sample, repeating every 4 cycles.
- Gapped valid: same data, `in_valid` on alternate cycles, `dump_len`=3 → `i_sum`=805306368 after 3 accepted samples; 5 accepted samples → exactly one pulse.
- Quadrature/sign: adc=−1000, cos=0, sin=2000, `dump_len`=10 → `i_sum`=0, `q_sum`=−20000000.
- Saturation: ACC_W=34, adc=cos=−32768, `dump_len`=16 → `i_sum`=8589934591, `sat`=1. The next window with adc=0 → `i_sum`=0, `sat`=0.
- Abort: `dump_len`=8, drop `en` after 5 samples, re-raise → no pulse from the partial window; the next window sums exactly 8 fresh samples.
- Reset mid-window: assert `sys_rst_n`=0 for 1 cycle after 3 of 4 samples → all outputs 0, no pulse. `dump_len`=0 → a pulse per sample with `i_sum` = that single product.
